sound_arbiter: RTL
==================

# sound_arbiter

Arbitrates the game's sound requests and sequences the single tone player. Requesters are the right push, left push, speed round and game win. The block picks one sound type at a time, holds each push sound for a minimum tick-based duration, and inserts a silent gap between sounds. It also buffers one pending push per side and lets the win sound preempt anything. It sits between the game FSM/input debouncers and the tone player, and drives the player's sound-type select and the amplifier shutdown pin.

## Interface
- DUR_PUSH, 4: push sound length in tick periods (1..15)
- DUR_WIN, 8: win sound length in tick periods (1..15)
- GAP_TICKS, 1: silent ticks between consecutive sounds (0..3; 0 = no gap)
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- tick  in  1  one-clk strobe from the slow enable divider; all durations count these
- req_right  in  1  one-clk pulse, right player pushed (ignored while req_win or win playing)
- req_left  in  1  one-clk pulse, left player pushed
- req_speed  in  1  level, speed round active
- req_win  in  1  one-clk pulse, game won
- sound_type  out  2  0 right tone, 1 left tone, 2 speed tone, 3 win tone
- notshutdown  out  1  amplifier enable; high only while a sound plays
- busy  out  1  high in any state except IDLE
- drop_cnt  out  4  saturating count of discarded push requests

## Operation
- States: IDLE, PLAY_PUSH, PLAY_SPEED, PLAY_WIN, GAP. Outputs are registered from state and current type.
- Pending flags pend_r and pend_l. A push pulse sets its flag unless that flag is already set; if it is already set, drop_cnt increments (saturates at 15).
- Effective requests: pend_x OR req_x in the current cycle.
- Priority: win > speed > right > left.
- IDLE:
  - req_win → PLAY_WIN.
  - Else req_speed → PLAY_SPEED.
  - Else effective right → PLAY_PUSH with type 0 and pend_r cleared.
  - Else effective left → PLAY_PUSH with type 1 and pend_l cleared.
- PLAY_PUSH: tick counter cnt starts at 0 and increments on tick. On the tick where cnt == DUR_PUSH-1, go to GAP, or to IDLE if GAP_TICKS == 0.
- PLAY_SPEED: type 2. Leaves on the first cycle req_speed is low, going to GAP/IDLE. Push requests arriving during speed stay pending, subject to drop rules.
- PLAY_WIN: entered from any state on req_win; cnt is reset to 0. Entry clears pend_r and pend_l without counting drops. Type 3. On the tick where cnt == DUR_WIN-1, go to IDLE with no gap. req_win while already in PLAY_WIN restarts cnt. Push pulses in PLAY_WIN are discarded without counting.
- GAP: notshutdown = 0 and sound_type holds its last value. Exits after GAP_TICKS ticks, re-arbitrating as in IDLE on the exit edge.
- Simultaneous req_right and req_left from IDLE: right plays and pend_l is set.
- A same-side pulse during its own PLAY_PUSH sets the pending flag. It does not extend the current sound.
- Reset values: state IDLE, sound_type 0, notshutdown 0, busy 0, drop_cnt 0, pend flags 0, cnt 0. Asserting rst mid-sound silences notshutdown immediately and asynchronously.

## Timing
- Request sampled high at edge N → state and outputs change at edge N, visible in cycle N+1. Latency is 1 clk from pulse to notshutdown high.
- Push sound length runs from the entry edge to the edge of the DUR_PUSH-th tick. The first period may be partial.
- The tick input and request pulses may coincide. The tick counts toward the state being exited, not the newly entered one.
- drop_cnt updates at the same edge the drop is detected.
- From GAP (exit) or IDLE, the next sound starts at the same edge as arbitration. There are no idle cycles beyond the gap.

## Test plan
- Ticks every 4 clk; req_right pulse from IDLE → sound_type 0, notshutdown 1 next cycle. Goes low after the 4th tick, stays silent 1 tick, busy drops to 0.
- req_right and req_left pulsed in the same cycle → right plays 4 ticks, gap 1 tick, then left (type 1) plays 4 ticks. drop_cnt stays 0.
- Three req_right pulses during one right sound → pend_r set by the first, drop_cnt = 2. Exactly two right sounds play.
- req_speed held 20 clk while a left pulse arrives → type 2 while req_speed is high. After release: gap, then type 1 for 4 ticks.
- Mid push sound, req_win pulses → next cycle type 3, pend flags cleared. notshutdown holds 8 ticks, then IDLE with busy 0.
- rst asserted mid win sound → notshutdown, busy, sound_type and drop_cnt are 0 without waiting for clk. After release, a req_left is served normally.

Source files
------------

// File: rtl/sound_arbiter.sv
`default_nettype none
// ============================================================================
// sound_arbiter : picks one game sound at a time for the tone player
// Rev 1.0
// ============================================================================
module sound_arbiter #(
   parameter int DUR_PUSH  = 4,
   parameter int DUR_WIN   = 8,
   parameter int GAP_TICKS = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       req_right,
   input  logic       req_left,
   input  logic       req_speed,
   input  logic       req_win,
   output logic [1:0] sound_type,
   output logic       notshutdown,
   output logic       busy,
   output logic [3:0] drop_cnt
);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_PLAY_PUSH  = 3'd1,
      S_PLAY_SPEED = 3'd2,
      S_PLAY_WIN   = 3'd3,
      S_GAP        = 3'd4
   } state_t;

   localparam logic [3:0] c_push_last  = 4'(DUR_PUSH - 1);
   localparam logic [3:0] c_win_last   = 4'(DUR_WIN - 1);
   localparam logic [3:0] c_gap_last   = 4'(GAP_TICKS - 1);
   localparam state_t     c_after      = (GAP_TICKS == 0) ? S_IDLE : S_GAP;
   localparam logic       c_after_busy = (GAP_TICKS != 0);

   state_t     r_state;
   state_t     w_arb_state;
   logic [3:0] r_cnt;
   logic [3:0] r_drop;
   logic [1:0] r_type;
   logic [1:0] w_arb_type;
   logic       r_pend_r;
   logic       r_pend_l;
   logic       w_win_ctx;
   logic       w_push_r;
   logic       w_push_l;
   logic       w_eff_r;
   logic       w_eff_l;
   logic       w_arb_clr_r;
   logic       w_arb_clr_l;
   logic       w_arbitrate;
   logic [4:0] w_drop_sum;
   logic [3:0] w_drop_nx;

   always_comb begin
      // pushes are swallowed silently whenever the win sound owns the player
      w_win_ctx   = req_win || (r_state == S_PLAY_WIN);
      w_push_r    = req_right && !w_win_ctx;
      w_push_l    = req_left && !w_win_ctx;
      w_eff_r     = r_pend_r || w_push_r;
      w_eff_l     = r_pend_l || w_push_l;
      w_drop_sum  = {1'b0, r_drop} + {4'd0, (w_push_r && r_pend_r)}
                                   + {4'd0, (w_push_l && r_pend_l)};
      w_drop_nx   = (w_drop_sum > 5'd15) ? 4'd15 : w_drop_sum[3:0];
      w_arbitrate = (r_state == S_IDLE) ||
                    ((r_state == S_GAP) && tick && (r_cnt == c_gap_last));
      w_arb_state = S_IDLE;
      w_arb_type  = r_type;
      w_arb_clr_r = 1'b0;
      w_arb_clr_l = 1'b0;
      if (req_speed) begin
         w_arb_state = S_PLAY_SPEED;
         w_arb_type  = 2'd2;
      end else if (w_eff_r) begin
         w_arb_state = S_PLAY_PUSH;
         w_arb_type  = 2'd0;
         w_arb_clr_r = 1'b1;
      end else if (w_eff_l) begin
         w_arb_state = S_PLAY_PUSH;
         w_arb_type  = 2'd1;
         w_arb_clr_l = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_type      <= 2'd0;
         r_pend_r    <= 1'b0;
         r_pend_l    <= 1'b0;
         r_drop      <= '0;
         notshutdown <= 1'b0;
         busy        <= 1'b0;
      end else begin
         r_drop <= w_drop_nx;
         if (req_win) begin
            r_state     <= S_PLAY_WIN;
            r_cnt       <= '0;
            r_type      <= 2'd3;
            r_pend_r    <= 1'b0;
            r_pend_l    <= 1'b0;
            notshutdown <= 1'b1;
            busy        <= 1'b1;
         end else if (w_arbitrate) begin
            r_state     <= w_arb_state;
            r_type      <= w_arb_type;
            r_cnt       <= '0;
            r_pend_r    <= w_eff_r && !w_arb_clr_r;
            r_pend_l    <= w_eff_l && !w_arb_clr_l;
            notshutdown <= (w_arb_state != S_IDLE);
            busy        <= (w_arb_state != S_IDLE);
         end else begin
            r_pend_r <= w_eff_r;
            r_pend_l <= w_eff_l;
            case (r_state)
               S_PLAY_PUSH: begin
                  if (tick) begin
                     if (r_cnt == c_push_last) begin
                        r_state     <= c_after;
                        r_cnt       <= '0;
                        notshutdown <= 1'b0;
                        busy        <= c_after_busy;
                     end else begin
                        r_cnt <= r_cnt + 4'd1;
                     end
                  end
               end
               S_PLAY_SPEED: begin
                  if (!req_speed) begin
                     r_state     <= c_after;
                     r_cnt       <= '0;
                     notshutdown <= 1'b0;
                     busy        <= c_after_busy;
                  end
               end
               S_PLAY_WIN: begin
                  if (tick) begin
                     if (r_cnt == c_win_last) begin
                        r_state     <= S_IDLE;
                        r_cnt       <= '0;
                        notshutdown <= 1'b0;
                        busy        <= 1'b0;
                     end else begin
                        r_cnt <= r_cnt + 4'd1;
                     end
                  end
               end
               S_GAP: begin
                  if (tick) begin
                     r_cnt <= r_cnt + 4'd1;
                  end
               end
               default: begin
                  r_state     <= S_IDLE;
                  notshutdown <= 1'b0;
                  busy        <= 1'b0;
               end
            endcase
         end
      end
   end

   assign sound_type = r_type;
   assign drop_cnt   = r_drop;

endmodule
`default_nettype wire
